fetch_hazard_ctrl: RTL

Pipeline control unit that drives the fetch stage's stall, flush and PC-redirect inputs. It sits between the EX/ID pipeline registers and the fetch stage.
- Detects load-use hazards and inserts bubbles.
- Turns taken branches and jumps resolved in EX into a redirect plus a flush.
- Sequences a halt/drain handshake.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 29 ++
 rtl/sat_counter.sv | 43 ++++
 rtl/fetch_hazard_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared definitions for the fetch-stage hazard controller:
//               FSM state encoding, register-index width, x0 index and an
//               operand-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef logic [1:0] ctrl_state_t;

    localparam ctrl_state_t ST_RUN    = 2'd0;
    localparam ctrl_state_t ST_LSTALL = 2'd1;
    localparam ctrl_state_t ST_DRAIN  = 2'd2;
    localparam ctrl_state_t ST_HALTED = 2'd3;

    // True when an operand is actually read and names the given register
    function automatic logic reg_match(input logic uses,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear (clear wins over
//               increment) and asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear first, then increment unless already at all-ones
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_hazard_ctrl
// Description : Drives fetch stall / flush / redirect. Detects load-use
//               hazards, turns EX redirects into flushes, sequences the
//               halt/drain handshake and keeps saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES      = 3,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_redirect,
    input  logic [31:0]       ex_target,
    input  logic              halt_req,
    input  logic              cnt_clr,
    output logic              stall_if,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              pc_src,
    output logic [31:0]       pc_jump,
    output logic              halt_ack,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // The first stall cycle is issued from RUN, so LSTALL covers the rest
    localparam bit         LSTALL_EN   = (LOAD_STALL_CYCLES > 1);
    localparam logic [2:0] LSTALL_INIT = LSTALL_EN ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
    localparam logic [2:0] DRAIN_INIT  = 3'(DRAIN_CYCLES - 1);

    ctrl_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        halt_ack_q, halt_ack_d;

    logic w_lu;
    logic w_rd;
    logic w_stall;
    logic w_flush_if_id;
    logic w_flush_id_ex;
    logic w_pc_src;

    assign w_lu = ex_valid && ex_mem_read && (ex_rd != REG_X0) &&
                  (reg_match(id_uses_rs1, id_rs1, ex_rd) ||
                   reg_match(id_uses_rs2, id_rs2, ex_rd));
    assign w_rd = ex_valid && ex_redirect;

    // State, shared down-counter and registered halt acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 3'd0;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    // Next state: redirect beats load-use, which beats halt
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (w_rd) begin
                    state_d = ST_RUN;
                end else if (w_lu) begin
                    if (LSTALL_EN) begin
                        state_d = ST_LSTALL;
                        cnt_d   = LSTALL_INIT;
                    end
                end else if (halt_req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end
            end
            ST_LSTALL: begin
                if (w_rd || (cnt_q == 3'd0)) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
        endcase
        halt_ack_d = (state_d == ST_HALTED);
    end

    // Mealy outputs from current state and this cycle's hazards
    always_comb begin
        w_stall       = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_pc_src      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (w_rd) begin
                    w_pc_src      = 1'b1;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                end else if (w_lu) begin
                    w_stall       = 1'b1;
                    w_flush_id_ex = 1'b1;
                end else if (halt_req) begin
                    w_stall       = 1'b1;
                    w_flush_if_id = 1'b1;
                end
            end
            ST_LSTALL: begin
                if (w_rd) begin
                    w_pc_src      = 1'b1;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                end else begin
                    w_stall       = 1'b1;
                    w_flush_id_ex = 1'b1;
                end
            end
            ST_DRAIN: begin
                // A redirect still loads the PC; the PC mux favours pc_src over stall
                w_stall       = 1'b1;
                w_flush_if_id = 1'b1;
                w_pc_src      = w_rd;
                w_flush_id_ex = w_rd;
            end
            default: begin
                w_stall       = 1'b1;
                w_flush_if_id = 1'b1;
            end
        endcase
    end

    // Combinational outputs are held low while reset is asserted
    assign stall_if    = rst && w_stall;
    assign flush_if_id = rst && w_flush_if_id;
    assign flush_id_ex = rst && w_flush_id_ex;
    assign pc_src      = rst && w_pc_src;
    assign pc_jump     = (rst && w_rd) ? ex_target : 32'd0;
    assign halt_ack    = halt_ack_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (stall_if),
        .i_clr   (cnt_clr),
        .o_count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (rst && w_rd),
        .i_clr   (cnt_clr),
        .o_count (flush_cnt)
    );

endmodule
`default_nettype wire
